// File: rtl/dpram_rr_arbiter.sv
// rtl/dpram_rr_arbiter.sv - two-requester arbiter sharing one dual-port RAM, read data routed by tag
// Define RAM_ARB_FIXPRI_EN for fixed priority (requester0 over requester1) instead of round-robin.
module dpram_rr_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            owner,
  output logic                  ram_csen_n,
  output logic                  ram_wren_n,
  output logic                  ram_rden_n,
  output logic [ADDR_WIDTH-1:0] ram_addr_wr,
  output logic [ADDR_WIDTH-1:0] ram_addr_rd,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  // State codes double as the owner output encoding.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  logic [1:0]            state, state_nxt;
  logic [HW-1:0]         hold_cnt, hold_nxt;
  logic                  last, last_nxt;
  logic                  rd_tag;
  logic                  own_id, own_req, oth_req;
  logic [1:0]            oth_state;
  logic                  beat, beat_wr;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [DATA_WIDTH-1:0] beat_wdata;

  assign owner     = state;
  assign gnt0      = (state == OWN0) && req0;
  assign gnt1      = (state == OWN1) && req1;
  assign own_id    = (state == OWN1);
  assign own_req   = own_id ? req1 : req0;
  assign oth_req   = own_id ? req0 : req1;
  assign oth_state = own_id ? OWN0 : OWN1;

  assign beat       = gnt0 || gnt1;
  assign beat_wr    = gnt1 ? wr1 : wr0;
  assign beat_addr  = gnt1 ? addr1 : addr0;
  assign beat_wdata = gnt1 ? wdata1 : wdata0;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        hold_nxt = '0;
`ifdef RAM_ARB_FIXPRI_EN
        if (req0)      state_nxt = OWN0;
        else if (req1) state_nxt = OWN1;
`else
        // last==1 means requester1 owned most recently, so requester0 wins a tie.
        if (req0 && (!req1 || last)) state_nxt = OWN0;
        else if (req1)               state_nxt = OWN1;
`endif
      end
      OWN0, OWN1: begin
        if (own_req) begin
          hold_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + HW'(1);
`ifdef RAM_ARB_FIXPRI_EN
          if (own_id && req0) begin
            state_nxt = OWN0;
            hold_nxt  = '0;
          end
`else
          if (oth_req && (hold_cnt == HOLD_LAST)) begin
            state_nxt = oth_state;
            hold_nxt  = '0;
            last_nxt  = own_id;
          end
`endif
        end else begin
          state_nxt = oth_req ? oth_state : IDLE;
          hold_nxt  = '0;
          last_nxt  = own_id;
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last     <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      last     <= last_nxt;
    end
  end

  // RAM pin stage, then read return stage; rd_tag follows each read to route its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_csen_n  <= 1'b1;
      ram_wren_n  <= 1'b1;
      ram_rden_n  <= 1'b1;
      ram_addr_wr <= '0;
      ram_addr_rd <= '0;
      ram_wdata   <= '0;
      rd_tag      <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata       <= '0;
    end else begin
      ram_csen_n <= !beat;
      ram_wren_n <= !(beat && beat_wr);
      ram_rden_n <= !(beat && !beat_wr);
      if (beat && beat_wr) begin
        ram_addr_wr <= beat_addr;
        ram_wdata   <= beat_wdata;
      end
      if (beat && !beat_wr) begin
        ram_addr_rd <= beat_addr;
        rd_tag      <= gnt1;
      end
      rvalid0 <= !ram_rden_n && !rd_tag;
      rvalid1 <= !ram_rden_n && rd_tag;
      if (!ram_rden_n) rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// tb/tb_dpram_rr_arbiter.sv - self-checking bench for dpram_rr_arbiter
// Directed vector table, hand sequences, and randomized traffic against a transaction-level model.
module tb_dpram_rr_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int MH = 4;
`ifdef RAM_ARB_FIXPRI_EN
  localparam bit FIXPRI = 1'b1;
`else
  localparam bit FIXPRI = 1'b0;
`endif

  logic          clk, rst_n;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [1:0]    owner;
  logic          ram_csen_n, ram_wren_n, ram_rden_n;
  logic [AW-1:0] ram_addr_wr, ram_addr_rd;
  logic [DW-1:0] ram_wdata, ram_rdata;

  dpram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .owner(owner),
    .ram_csen_n(ram_csen_n), .ram_wren_n(ram_wren_n), .ram_rden_n(ram_rden_n),
    .ram_addr_wr(ram_addr_wr), .ram_addr_rd(ram_addr_rd),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench RAM: writes on the clock edge, read output follows the registered read address.
  logic [DW-1:0] mem [16];
  logic          init_en;
  logic [AW-1:0] init_a;
  logic [DW-1:0] init_d;
  always @(posedge clk) begin
    if (init_en) mem[init_a] <= init_d;
    else if (!ram_csen_n && !ram_wren_n) mem[ram_addr_wr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr_rd];

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 37 + 11);
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  // Asserts reset just after an edge, holds it for three cycles with random requests, releases mid-cycle.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      req0 = 1'($urandom); req1 = 1'($urandom);
      wr0 = 1'($urandom); wr1 = 1'($urandom);
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      @(negedge clk);
      chk("rst_pins",   32'({ram_csen_n, ram_wren_n, ram_rden_n}), 32'(3'b111));
      chk("rst_gnt",    32'({gnt0, gnt1}), 32'(2'b00));
      chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'(2'b00));
      chk("rst_owner",  32'(owner), 32'(2'b00));
      chk("rst_regs",   32'({ram_addr_wr, ram_addr_rd, ram_wdata, rdata}), 32'(0));
    end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic          r1, w1; logic [AW-1:0] a1;
    logic          g0, g1; logic [1:0] own;
    logic          v0, v1; logic [DW-1:0] rd;
    logic [2:0]    pins;
    logic          wchk; logic [AW-1:0] wa; logic [DW-1:0] wd;
  } vec_t;

  vec_t tbl [12];

  // Transaction-level reference model state.
  int            m_own, m_streak;
  logic          m_last, me, mine, theirs, g0m, g1m, beat, bw;
  logic [AW-1:0] ba;
  logic [DW-1:0] bd;
  logic [2:0]    exp_pins;
  logic          exp_wchk, exp_rchk;
  logic [AW-1:0] exp_wa, exp_ra;
  logic [DW-1:0] exp_wd;
  logic [DW-1:0] ref_mem [16];
  logic          ev_v [4];
  logic          ev_t [4];
  logic [DW-1:0] ev_d [4];
  logic          p0, p1, pw0, pw1;
  logic [AW-1:0] pa0, pa1;
  logic [DW-1:0] pd0, pd1;
  logic          h0 [32];
  logic          h1 [32];
  logic          e0, e1;

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    init_en = 1'b0; init_a = '0; init_d = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      init_en = 1'b1; init_a = AW'(i); init_d = init_val(i);
    end
    @(posedge clk); #1;
    init_en = 1'b0;

    // Write then ownership switch and read-back; then same-owner write followed by read of that address.
    tbl[0]  = '{1'b1,1'b1,4'd3,8'hA5, 1'b0,1'b0,4'd0, 1'b0,1'b0,2'd0, 1'b0,1'b0,8'h00, 3'b111, 1'b0,4'd0,8'h00};
    tbl[1]  = '{1'b1,1'b1,4'd3,8'hA5, 1'b0,1'b0,4'd0, 1'b1,1'b0,2'd1, 1'b0,1'b0,8'h00, 3'b111, 1'b0,4'd0,8'h00};
    tbl[2]  = '{1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,4'd3, 1'b0,1'b0,2'd1, 1'b0,1'b0,8'h00, 3'b001, 1'b1,4'd3,8'hA5};
    tbl[3]  = '{1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,4'd3, 1'b0,1'b1,2'd2, 1'b0,1'b0,8'h00, 3'b111, 1'b0,4'd0,8'h00};
    tbl[4]  = '{1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0, 1'b0,1'b0,2'd2, 1'b0,1'b0,8'h00, 3'b010, 1'b0,4'd0,8'h00};
    tbl[5]  = '{1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0, 1'b0,1'b0,2'd0, 1'b0,1'b1,8'hA5, 3'b111, 1'b0,4'd0,8'h00};
    tbl[6]  = '{1'b1,1'b1,4'd5,8'h3C, 1'b0,1'b0,4'd0, 1'b0,1'b0,2'd0, 1'b0,1'b0,8'hA5, 3'b111, 1'b0,4'd0,8'h00};
    tbl[7]  = '{1'b1,1'b1,4'd5,8'h3C, 1'b0,1'b0,4'd0, 1'b1,1'b0,2'd1, 1'b0,1'b0,8'hA5, 3'b111, 1'b0,4'd0,8'h00};
    tbl[8]  = '{1'b1,1'b0,4'd5,8'h00, 1'b0,1'b0,4'd0, 1'b1,1'b0,2'd1, 1'b0,1'b0,8'hA5, 3'b001, 1'b1,4'd5,8'h3C};
    tbl[9]  = '{1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0, 1'b0,1'b0,2'd1, 1'b0,1'b0,8'hA5, 3'b010, 1'b0,4'd0,8'h00};
    tbl[10] = '{1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0, 1'b0,1'b0,2'd0, 1'b1,1'b0,8'h3C, 3'b111, 1'b0,4'd0,8'h00};
    tbl[11] = '{1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0, 1'b0,1'b0,2'd0, 1'b0,1'b0,8'h3C, 3'b111, 1'b0,4'd0,8'h00};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      req0 = tbl[i].r0; wr0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; wr1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = '0;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i),    32'({gnt0, gnt1}), 32'({tbl[i].g0, tbl[i].g1}));
      chk($sformatf("vec%0d_owner", i),  32'(owner), 32'(tbl[i].own));
      chk($sformatf("vec%0d_rvalid", i), 32'({rvalid0, rvalid1}), 32'({tbl[i].v0, tbl[i].v1}));
      chk($sformatf("vec%0d_rdata", i),  32'(rdata), 32'(tbl[i].rd));
      chk($sformatf("vec%0d_pins", i),   32'({ram_csen_n, ram_wren_n, ram_rden_n}), 32'(tbl[i].pins));
      if (tbl[i].wchk)
        chk($sformatf("vec%0d_wport", i), 32'({ram_addr_wr, ram_wdata}), 32'({tbl[i].wa, tbl[i].wd}));
    end

    // Both requesters held with reads: grant pattern and tag routing across owner switches.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      req0 = !(FIXPRI && c >= 12); req1 = 1'b1;
      wr0 = 1'b0; wr1 = 1'b0; addr0 = 4'd1; addr1 = 4'd2;
      @(negedge clk);
`ifdef RAM_ARB_FIXPRI_EN
      e0 = (c > 0) && (c < 12);
      e1 = (c >= 13);
      if (c == 12) chk("fix_drop_owner", 32'(owner), 32'(2'd1));
      if (c == 13) chk("fix_switch_owner", 32'(owner), 32'(2'd2));
`else
      e0 = (c > 0) && (((c - 1) / MH) % 2 == 0);
      e1 = (c > 0) && !e0;
`endif
      chk($sformatf("cont%0d_gnt", c), 32'({gnt0, gnt1}), 32'({e0, e1}));
      h0[c] = e0; h1[c] = e1;
      if (c >= 2) begin
        chk($sformatf("cont%0d_rvalid", c), 32'({rvalid0, rvalid1}), 32'({h0[c-2], h1[c-2]}));
        if (h0[c-2]) chk($sformatf("cont%0d_rdata0", c), 32'(rdata), 32'(init_val(1)));
        if (h1[c-2]) chk($sformatf("cont%0d_rdata1", c), 32'(rdata), 32'(init_val(2)));
      end
    end

    // Reset the cycle after a read grant: the read must vanish and the next tie goes to requester0.
    do_reset();
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd7;
    @(negedge clk);
    chk("mid_bubble_owner", 32'(owner), 32'(2'd0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_gnt0", 32'(gnt0), 32'(1'b1));
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_after_rvalid", 32'({rvalid0, rvalid1}), 32'(2'b00));
      chk("mid_after_owner", 32'(owner), 32'(2'd0));
    end
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
    chk("mid_tie_bubble", 32'({gnt0, gnt1, owner}), 32'({2'b00, 2'd0}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_tie_winner", 32'({gnt0, gnt1, owner}), 32'({2'b10, 2'd1}));

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < 4; i++) ev_v[i] = 1'b0;
    m_own = 0; m_streak = 0; m_last = 1'b1;
    exp_pins = 3'b111; exp_wchk = 1'b0; exp_rchk = 1'b0;
    exp_wa = '0; exp_ra = '0; exp_wd = '0;
    p0 = 1'b0; p1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!p0 && $urandom_range(0, 9) < 7) begin
        p0 = 1'b1; pw0 = 1'($urandom); pa0 = AW'($urandom_range(0, 3)); pd0 = DW'($urandom);
      end
      if (!p1 && $urandom_range(0, 9) < (((c / 200) % 2 == 1) ? 1 : 7)) begin
        p1 = 1'b1; pw1 = 1'($urandom); pa1 = AW'($urandom_range(0, 3)); pd1 = DW'($urandom);
      end
      req0 = p0; wr0 = pw0; addr0 = pa0; wdata0 = pd0;
      req1 = p1; wr1 = pw1; addr1 = pa1; wdata1 = pd1;
      @(negedge clk);
      g0m = (m_own == 1) && req0;
      g1m = (m_own == 2) && req1;
      chk("rnd_gnt",   32'({gnt0, gnt1}), 32'({g0m, g1m}));
      chk("rnd_owner", 32'(owner), 32'(m_own));
      chk("rnd_pins",  32'({ram_csen_n, ram_wren_n, ram_rden_n}), 32'(exp_pins));
      if (exp_wchk) chk("rnd_wport", 32'({ram_addr_wr, ram_wdata}), 32'({exp_wa, exp_wd}));
      if (exp_rchk) chk("rnd_raddr", 32'(ram_addr_rd), 32'(exp_ra));
      chk("rnd_rvalid", 32'({rvalid0, rvalid1}),
          32'({ev_v[c%4] && !ev_t[c%4], ev_v[c%4] && ev_t[c%4]}));
      if (ev_v[c%4]) chk("rnd_rdata", 32'(rdata), 32'(ev_d[c%4]));
      ev_v[c%4] = 1'b0;

      beat = g0m || g1m;
      bw = g1m ? wr1 : wr0;
      ba = g1m ? addr1 : addr0;
      bd = g1m ? wdata1 : wdata0;
      exp_pins = !beat ? 3'b111 : (bw ? 3'b001 : 3'b010);
      exp_wchk = beat && bw;
      exp_rchk = beat && !bw;
      if (exp_wchk) begin exp_wa = ba; exp_wd = bd; ref_mem[ba] = bd; end
      if (exp_rchk) begin
        exp_ra = ba;
        ev_v[(c+2)%4] = 1'b1; ev_t[(c+2)%4] = g1m; ev_d[(c+2)%4] = ref_mem[ba];
      end

      if (m_own == 0) begin
        m_streak = 0;
        if (req0 && req1) m_own = (FIXPRI || m_last) ? 1 : 2;
        else if (req0)    m_own = 1;
        else if (req1)    m_own = 2;
      end else begin
        me = (m_own == 2);
        mine = me ? req1 : req0;
        theirs = me ? req0 : req1;
        if (mine) begin
          m_streak++;
          if (theirs && (FIXPRI ? me : (m_streak >= MH))) begin
            m_last = me; m_own = 3 - m_own; m_streak = 0;
          end
        end else begin
          m_last = me; m_streak = 0;
          m_own = theirs ? 3 - m_own : 0;
        end
      end
      if (g0m) p0 = 1'b0;
      if (g1m) p1 = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
